inv_sub_bytes_engine: RTL
=========================

Name: inv_sub_bytes_engine

Overview:
Iterative AES InvSubBytes unit for the decryption datapath. Accepts a 128-bit AES state over a valid/ready handshake and applies the inverse S-box to BYTES_PER_CYCLE bytes per clock. Returns the substituted state over a second valid/ready handshake. Sits between the inverse ShiftRows and AddRoundKey stages of the decrypt round loop.

Parameters:
BYTES_PER_CYCLE, 4, bytes substituted per clock; legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
NUM_STEPS, 16/BYTES_PER_CYCLE, derived and not overridable; number of substitution cycles per block.

Ports:
clk  in  1  single clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  in_data is valid
in_ready  out  1  engine can accept a block
in_data  in  128  state in; byte 0 = [127:120], byte 15 = [7:0]
out_valid  out  1  out_data is valid
out_ready  in  1  downstream accepts out_data
out_data  out  128  substituted state, same byte order as in_data
busy  out  1  high in BUSY and DONE

Behaviour:
- Reset (clk edge with reset=1): state IDLE, out_valid=0, out_data=0, busy=0, step counter=0. in_ready=1 from the cycle after reset deasserts. reset overrides every other input.
- States:
  - IDLE: in_ready=1. When in_valid=1, capture in_data into the work register, clear the counter, and go to BUSY.
  - BUSY: in_ready=0. Each cycle, replace bytes [step*BPC .. step*BPC+BPC-1] with InvSbox(byte) in place, then step+1. On step==NUM_STEPS-1, go to DONE.
  - DONE: out_valid=1 and out_data = work register, held stable until out_ready=1. On out_valid && out_ready, go to IDLE; out_valid drops the next cycle.
- Latency: out_valid rises NUM_STEPS+1 cycles after the accept edge. With BPC=4 this is 5 cycles. With out_ready held high, minimum block spacing is NUM_STEPS+2 cycles.
- in_ready is 0 in DONE. A new block cannot be accepted in the same cycle as the output handshake.
- in_data and in_valid are ignored outside IDLE.
- out_ready is ignored outside DONE.
- The step counter is $clog2(NUM_STEPS) bits wide, minimum 1. It wraps to 0 on the BUSY→DONE transition.
- InvSbox is the exact inverse of the team's forward S-box: InvSbox(Sbox(x)) = x for all 256 x, e.g. InvSbox(0x63)=0x00, InvSbox(0x16)=0xFF.
- Reset mid-BUSY or mid-DONE: the block is discarded with no output, and the engine returns to IDLE.
- out_data is unchanged (last value) in IDLE and BUSY. It is meaningful only when out_valid=1.

Optional Feature:
SBOX_FWD_MODE_EN
- Defined:
  - Adds input port fwd_mode (1 bit), sampled together with in_data on accept.
  - If fwd_mode=1, the block uses the forward S-box (encrypt SubBytes); otherwise it uses the inverse.
  - Mode is held constant for the whole block.
  - A second lookup sub-module instance is muxed per byte lane.
- Undefined: the fwd_mode port does not exist, and the block always applies the inverse S-box.

Decomposition:
- Shared package aes_pkg holds:
  - AES_STATE_W=128 and AES_BYTES=16
  - typedef aes_byte_t (8-bit) and aes_state_t (128-bit)
  - the FSM enum {IDLE, BUSY, DONE}
- Sub-module inv_sbox_lookup: purely combinational 8-bit→8-bit inverse S-box, instantiated BYTES_PER_CYCLE times, one per lane.

Test Plan:
- Reset, then all-0x63 state, out_ready=1 → out_valid on cycle 5 after accept (BPC=4), out_data = all-0x00. busy is high for 5 cycles, then drops after the handshake.
- in_data = 0x000102…0F → out_data = 0x52096AD53036A538BF40A39E81F3D7FB.
- Round trip: for all 256 byte values packed into 16 blocks, feed Sbox(x) → output equals x, byte order preserved.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid=1 and out_data stable throughout, in_ready=0, in_valid pulses ignored. Release → one handshake, return to IDLE.
- Reset asserted on the 2nd BUSY cycle → next cycle out_valid=0, busy=0, in_ready=1. The following block (all-0x00) yields all-0x52 with no residue from the aborted block.
- Sweep BYTES_PER_CYCLE=1, 2, 8, 16 → latency is 17, 9, 3, 2 cycles respectively, with identical out_data. With SBOX_FWD_MODE_EN and fwd_mode=1, all-0x00 → all-0x63.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: state/byte types, engine FSM encoding and S-box tables.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef logic [7:0]             aes_byte_t;
  typedef logic [AES_STATE_W-1:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Entry 0 sits in the top byte of each table.
  localparam logic [2047:0] FWD_SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic aes_byte_t sbox_fwd(aes_byte_t x);
    return FWD_SBOX_TABLE[8*(255-int'(x)) +: 8];
  endfunction

  function automatic aes_byte_t sbox_inv(aes_byte_t x);
    return INV_SBOX_TABLE[8*(255-int'(x)) +: 8];
  endfunction

endpackage

// File: rtl/inv_sbox_lookup.sv
// Combinational byte lookup; inverse S-box by default, forward S-box when FWD=1.
module inv_sbox_lookup
  import aes_pkg::*;
#(
  parameter bit FWD = 1'b0
) (
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = FWD ? sbox_fwd(a) : sbox_inv(a);

endmodule

// File: rtl/inv_sub_bytes_engine.sv
// Iterative AES InvSubBytes: BYTES_PER_CYCLE lanes walk the 16-byte state in place.
// Define SBOX_FWD_MODE_EN to add a fwd_mode input selecting the forward S-box per block.
//
// state | meaning
// IDLE  | in_ready high, waiting for a block
// BUSY  | substituting one group of lanes per cycle
// DONE  | out_valid high, holding out_data until out_ready
module inv_sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_data,
`ifdef SBOX_FWD_MODE_EN
  input  logic                   fwd_mode,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_data,
  output logic                   busy
);

  localparam int NUM_STEPS = AES_BYTES / BYTES_PER_CYCLE;
  localparam int CW        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(NUM_STEPS - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("inv_sub_bytes_engine: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_t     state;
  logic [CW-1:0] step;
  aes_state_t work;
  aes_state_t work_nxt;
  logic       mode;
  aes_byte_t  lane_in  [BYTES_PER_CYCLE];
  aes_byte_t  lane_out [BYTES_PER_CYCLE];

  for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
    // Byte 0 of the state lives in the top byte of the vector.
    assign lane_in[l] = work[8*(AES_BYTES-1-(int'(step)*BYTES_PER_CYCLE+l)) +: 8];
`ifdef SBOX_FWD_MODE_EN
    aes_byte_t inv_y, fwd_y;
    inv_sbox_lookup #(.FWD(1'b0)) u_inv (.a(lane_in[l]), .y(inv_y));
    inv_sbox_lookup #(.FWD(1'b1)) u_fwd (.a(lane_in[l]), .y(fwd_y));
    assign lane_out[l] = mode ? fwd_y : inv_y;
`else
    inv_sbox_lookup #(.FWD(1'b0)) u_inv (.a(lane_in[l]), .y(lane_out[l]));
`endif
  end

  always_comb begin
    work_nxt = work;
    for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
      work_nxt[8*(AES_BYTES-1-(int'(step)*BYTES_PER_CYCLE+l)) +: 8] = lane_out[l];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      step     <= '0;
      work     <= '0;
      out_data <= '0;
      mode     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            step  <= '0;
            state <= BUSY;
`ifdef SBOX_FWD_MODE_EN
            mode  <= fwd_mode;
`else
            mode  <= 1'b0;
`endif
          end
        end
        BUSY: begin
          work <= work_nxt;
          if (step == LAST_STEP) begin
            step     <= '0;
            out_data <= work_nxt;
            state    <= DONE;
          end else begin
            step <= step + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY) || (state == DONE);

endmodule
